// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Active scanner for a 4x4 matrix keypad. Drives one column low at a time,
//   samples the pulled-up rows through a 2-flop synchronizer, debounces press
//   and release, and reports the accepted key as {col_idx, row_idx}.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   enable     scanning enable; low parks the block in IDLE, columns released
//   row_in     raw row lines, active-low, asynchronous to clk
//   col_drive  column strobes, active-low one-hot while scanning, 4'b1111 idle
//   key_code   code of the last accepted key
//   key_valid  one-cycle pulse when a debounced press is accepted
//   key_held   high from acceptance until debounced release
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] row_in,
    output logic [3:0] col_drive,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned MAX_CNT = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DEBOUNCE, HELD} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    col_idx;
    logic [1:0]    row_idx;
    logic [3:0]    row_cap;
    logic [3:0]    row_meta;
    logic [3:0]    row_s;

    logic          row_single;
    logic [1:0]    row_dec;

    // Index i selects the pattern with bit (3-i) low.
    function automatic logic [3:0] col_pat(input logic [1:0] idx);
        logic [3:0] p;
        p = '1;
        p[3 - idx] = 1'b0;
        return p;
    endfunction

    // Exactly one row low is a valid key; none or several (ghosting) is not.
    always_comb begin
        row_single = 1'b1;
        row_dec    = 2'd0;
        case (row_s)
            4'b0111: row_dec = 2'd0;
            4'b1011: row_dec = 2'd1;
            4'b1101: row_dec = 2'd2;
            4'b1110: row_dec = 2'd3;
            default: row_single = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= '1;
            row_s    <= '1;
        end else begin
            row_meta <= row_in;
            row_s    <= row_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            col_idx   <= '0;
            row_idx   <= '0;
            row_cap   <= '1;
            col_drive <= '1;
            key_code  <= '1;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (!enable) begin
                state     <= IDLE;
                cnt       <= '0;
                col_idx   <= '0;
                col_drive <= '1;
                key_held  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= SCAN;
                        cnt       <= '0;
                        col_idx   <= '0;
                        col_drive <= col_pat(2'd0);
                    end
                    SCAN: begin
                        if (cnt == SCAN_LAST) begin
                            cnt <= '0;
                            if (row_single) begin
                                state   <= DEBOUNCE;
                                row_idx <= row_dec;
                                row_cap <= row_s;
                            end else begin
                                col_idx   <= col_idx + 2'd1;
                                col_drive <= col_pat(col_idx + 2'd1);
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DEBOUNCE: begin
                        if (row_s != row_cap) begin
                            // Bounce: rescan the same column from a fresh dwell.
                            state <= SCAN;
                            cnt   <= '0;
                        end else if (cnt == DEB_LAST) begin
                            state     <= HELD;
                            cnt       <= '0;
                            key_code  <= {col_idx, row_idx};
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    HELD: begin
                        if (row_s != 4'b1111) begin
                            cnt <= '0;
                        end else if (cnt == DEB_LAST) begin
                            state     <= SCAN;
                            cnt       <= '0;
                            key_held  <= 1'b0;
                            col_idx   <= col_idx + 2'd1;
                            col_drive <= col_pat(col_idx + 2'd1);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        cnt       <= '0;
                        col_drive <= '1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Scoreboard bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
//   A keypad model pulls the selected row pattern low whenever the pressed
//   key's column is driven; expected key codes are queued as presses are made.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] row_in;
    logic [3:0] col_drive;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [3:0] exp_q[$];

    logic       key_on  = 1'b0;
    logic [1:0] key_col = 2'd0;
    logic [3:0] key_pat = 4'b1111;
    logic [3:0] prev_code = 4'b1111;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .row_in   (row_in),
        .col_drive(col_drive),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] pat(input int i);
        logic [3:0] p;
        p = 4'b1111;
        p[3 - i] = 1'b0;
        return p;
    endfunction

    assign row_in = (key_on && col_drive == pat(int'(key_col))) ? key_pat : 4'b1111;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every key_valid must match the oldest expected code.
    always @(negedge clk) begin
        if (!rst && key_valid) begin
            if (exp_q.size() == 0) check("unexpected_valid", {28'd0, key_code}, 32'hFFFF_FFFF);
            else check("key_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
        end
    end

    // key_code may only change on the key_valid cycle.
    always @(negedge clk) begin
        if (rst) prev_code = key_code;
        else begin
            if (key_code != prev_code) check("code_change_valid", {31'd0, key_valid}, 32'd1);
            prev_code = key_code;
        end
    end

    task automatic wait_valid(input string tag, input int max);
        bit seen;
        seen = 0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (key_valid) seen = 1;
        end
        if (!seen) check(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_col(input string tag, input logic [3:0] p, input bit want_eq, input int max);
        bit ok;
        ok = 0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if ((col_drive == p) == want_eq) ok = 1;
        end
        if (!ok) check(tag, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seen_cols;
        rst    = 1'b1;
        enable = 1'b0;
        #12;
        check("rst_col", {28'd0, col_drive}, 32'hF);
        check("rst_code", {28'd0, key_code}, 32'hF);
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_held", {31'd0, key_held}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_col", {28'd0, col_drive}, 32'hF);

        // Free scan: each column held 4 cycles, in order.
        enable = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 20; j++) begin
            check("scan_seq", {28'd0, col_drive}, {28'd0, pat((j / 4) % 4)});
            @(negedge clk);
        end

        // Clean press: column 2 (1101), row 1 (1011) -> code 9.
        key_col = 2'd2;
        key_pat = 4'b1011;
        exp_q.push_back(4'h9);
        key_on = 1'b1;
        wait_valid("timeout_press", 200);
        check("press_held", {31'd0, key_held}, 32'd1);
        repeat (20) @(negedge clk);
        check("press_col_frozen", {28'd0, col_drive}, 32'hD);
        check("press_held_late", {31'd0, key_held}, 32'd1);
        key_on = 1'b0;
        begin
            bit dropped;
            dropped = 0;
            for (int i = 0; i < 40 && !dropped; i++) begin
                @(negedge clk);
                if (!key_held) dropped = 1;
            end
            check("release_seen", {31'd0, dropped}, 32'd1);
        end
        check("release_next_col", {28'd0, col_drive}, 32'hE);

        // Bouncing press then bouncing release.
        for (int i = 0; i < 15; i++) begin
            key_on = ((i / 3) % 2) == 0;
            @(negedge clk);
        end
        key_on = 1'b1;
        exp_q.push_back(4'h9);
        wait_valid("timeout_bounce_press", 300);
        check("bounce_held", {31'd0, key_held}, 32'd1);
        for (int i = 0; i < 15; i++) begin
            key_on = ((i / 3) % 2) == 1;
            @(negedge clk);
        end
        check("bounce_rel_held", {31'd0, key_held}, 32'd1);
        key_on = 1'b1;
        repeat (4) @(negedge clk);
        key_on = 1'b0;
        repeat (9) @(negedge clk);
        check("rel_held_before", {31'd0, key_held}, 32'd1);
        @(negedge clk);
        check("rel_held_after", {31'd0, key_held}, 32'd0);
        check("rel_resume_col", {28'd0, col_drive}, 32'hE);

        // Ghost: two rows low on column 0, must never be accepted.
        key_col = 2'd0;
        key_pat = 4'b0011;
        key_on  = 1'b1;
        seen_cols = 4'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++)
                if (col_drive == pat(c)) seen_cols[c] = 1'b1;
        end
        check("ghost_advance", {28'd0, seen_cols}, 32'hF);
        check("ghost_held", {31'd0, key_held}, 32'd0);
        key_on = 1'b0;

        // Disable mid-debounce on column 3 / row 3.
        key_col = 2'd3;
        key_pat = 4'b1110;
        key_on  = 1'b1;
        wait_col("timeout_leave_c3", 4'b1110, 1'b0, 40);
        wait_col("timeout_reach_c3", 4'b1110, 1'b1, 40);
        repeat (6) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("dis_col", {28'd0, col_drive}, 32'hF);
        check("dis_held", {31'd0, key_held}, 32'd0);
        check("dis_code_kept", {28'd0, key_code}, 32'h9);
        repeat (3) @(negedge clk);
        enable = 1'b1;
        exp_q.push_back(4'hF);
        @(negedge clk);
        check("reen_col", {28'd0, col_drive}, 32'h7);

        // Asynchronous reset while HELD.
        wait_valid("timeout_press_f", 200);
        repeat (3) @(negedge clk);
        check("pre_rst_held", {31'd0, key_held}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_col", {28'd0, col_drive}, 32'hF);
        check("arst_code", {28'd0, key_code}, 32'hF);
        check("arst_valid", {31'd0, key_valid}, 32'd0);
        check("arst_held", {31'd0, key_held}, 32'd0);
        key_on = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_col", {28'd0, col_drive}, 32'h7);
        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
